// File: rtl/exu_issue_buf.sv
// Two-entry skid buffer between decode and the ALU: muxes operands at the
// input, registers them with ctr/rd/wen/pc, and counts back-pressure cycles.
module exu_issue_buf #(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_asel,
  input  logic [1:0]      in_bsel,
  input  logic [3:0]      in_ctr,
  input  logic [RW-1:0]   in_rd,
  input  logic            in_wen,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [3:0]      out_ctr,
  output logic [RW-1:0]   out_rd,
  output logic            out_wen,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     stall_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] pc;
    logic [3:0]      ctr;
    logic [RW-1:0]   rd;
    logic            wen;
  } entry_t;

  state_t      state_q, state_d;
  entry_t      main_q, skid_q, in_entry;
  logic [31:0] stall_cnt_q;
  logic        in_fire, out_fire;
  logic        load_main_in, load_main_skid, load_skid;

  // Both handshake outputs come straight from the state register, so
  // out_ready never reaches in_ready combinationally.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    in_entry.a   = in_asel ? in_pc : in_rs1;
    in_entry.pc  = in_pc;
    in_entry.ctr = in_ctr;
    in_entry.rd  = in_rd;
    in_entry.wen = in_wen;
    unique case (in_bsel)
      2'b00:   in_entry.b = in_rs2;
      2'b01:   in_entry.b = in_imm;
      2'b10:   in_entry.b = XLEN'(4);
      default: in_entry.b = '0;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (in_fire) begin
          load_main_in = 1'b1;
          state_d      = ONE;
        end
        ONE: if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (out_fire) begin
          state_d = EMPTY;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end
        FULL: if (out_fire) begin
          load_main_skid = 1'b1;
          state_d        = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the two payload slots are reset so out_* read as zero after reset;
  // outside reset an invalid slot's contents are never looked at.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_entry;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_entry;
      end
    end
  end

  // Counts stalls even in a flush cycle; wraps naturally at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign out_a     = main_q.a;
  assign out_b     = main_q.b;
  assign out_pc    = main_q.pc;
  assign out_ctr   = main_q.ctr;
  assign out_rd    = main_q.rd;
  assign out_wen   = main_q.wen;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_exu_issue_buf.sv
// Directed bench for exu_issue_buf: reset, operand muxing, back-pressure,
// streaming, flush and stall counter wrap, all against hand-computed values.
module tb_exu_issue_buf;

  logic        clk, rst, flush, in_valid, in_ready;
  logic [31:0] in_rs1, in_rs2, in_imm, in_pc;
  logic        in_asel;
  logic [1:0]  in_bsel;
  logic [3:0]  in_ctr;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        out_valid, out_ready;
  logic [31:0] out_a, out_b, out_pc, stall_cnt;
  logic [3:0]  out_ctr;
  logic [4:0]  out_rd;
  logic        out_wen;

  int total = 0;
  int bad   = 0;

  exu_issue_buf #(.XLEN(32), .RW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc),
    .in_asel(in_asel), .in_bsel(in_bsel), .in_ctr(in_ctr),
    .in_rd(in_rd), .in_wen(in_wen),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_ctr(out_ctr),
    .out_rd(out_rd), .out_wen(out_wen), .out_pc(out_pc),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic asel, input logic [1:0] bsel,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [31:0] pc,
                       input logic [3:0] ctr, input logic [4:0] rd, input logic wen);
    in_valid = v;   in_asel = asel; in_bsel = bsel;
    in_rs1   = rs1; in_rs2  = rs2;  in_imm  = imm; in_pc = pc;
    in_ctr   = ctr; in_rd   = rd;   in_wen  = wen;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0);
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    // in_valid during reset must be ignored
    drive(1'b1, 1'b0, 2'b00, 32'h1234, 32'h5678, 32'h9, 32'h40, 4'h3, 5'd7, 1'b1);
    step();
    step();
    check_empty("rst");
    check("rst_a", out_a, 32'h0);
    check("rst_b", out_b, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_tags", {23'd0, out_ctr, out_rd, out_wen}, 32'h0);
    check("rst_stall", stall_cnt, 32'h0);
    rst = 1'b0;
    idle();
    step();
    check_empty("post_rst");

    // Fill to FULL, then assert rst asynchronously mid-cycle
    drive(1'b1, 1'b0, 2'b11, 32'hAA, 32'h0, 32'h0, 32'h0, 4'h1, 5'd1, 1'b1);
    step();
    drive(1'b1, 1'b0, 2'b11, 32'hBB, 32'h0, 32'h0, 32'h0, 4'h2, 5'd2, 1'b1);
    step();
    check("pre_rst_full", {31'd0, in_ready}, 32'd0);
    check("pre_rst_stall", stall_cnt, 32'd1);
    #3 rst = 1'b1;
    #1;
    check_empty("async_rst");
    check("async_rst_stall", stall_cnt, 32'd0);
    check("async_rst_a", out_a, 32'h0);
    #2 rst = 1'b0;
    idle();
    step();
    check_empty("after_async_rst");

    // Operand select, streaming through with out_ready=1
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 2'b01, 32'h10, 32'h0, 32'h5, 32'h0, 4'h0, 5'd3, 1'b1);
    step();
    check("op1_valid", {31'd0, out_valid}, 32'd1);
    check("op1_a", out_a, 32'h10);
    check("op1_b", out_b, 32'h5);
    check("op1_ctr", {28'd0, out_ctr}, 32'h0);
    check("op1_rd", {27'd0, out_rd}, 32'd3);
    drive(1'b1, 1'b1, 2'b10, 32'h77, 32'h0, 32'h0, 32'h8000_0000, 4'h6, 5'd4, 1'b0);
    step();
    check("op2_a", out_a, 32'h8000_0000);
    check("op2_b", out_b, 32'd4);
    check("op2_pc", out_pc, 32'h8000_0000);
    check("op2_tags", {23'd0, out_ctr, out_rd, out_wen}, {23'd0, 4'h6, 5'd4, 1'b0});
    drive(1'b1, 1'b0, 2'b11, 32'h7, 32'h99, 32'h55, 32'h100, 4'hA, 5'd5, 1'b1);
    step();
    check("op3_a", out_a, 32'h7);
    check("op3_b", out_b, 32'h0);
    drive(1'b1, 1'b0, 2'b00, 32'h1, 32'hDEAD_BEEF, 32'h55, 32'h104, 4'hF, 5'd6, 1'b1);
    step();
    check("op4_b", out_b, 32'hDEAD_BEEF);
    check("op4_ctr", {28'd0, out_ctr}, 32'hF);
    idle();
    step();
    check("op_drain", {31'd0, out_valid}, 32'd0);
    check("op_stall", stall_cnt, 32'd0);

    // Back-pressure: E1 into MAIN, E2 into SKID, then hold
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 2'b11, 32'h111, 32'h0, 32'h0, 32'h0, 4'h1, 5'd10, 1'b1);
    step();
    check("bp_e1_ready", {31'd0, in_ready}, 32'd1);
    check("bp_e1_rd", {27'd0, out_rd}, 32'd10);
    drive(1'b1, 1'b0, 2'b11, 32'h222, 32'h0, 32'h0, 32'h0, 4'h2, 5'd11, 1'b1);
    step();
    // E3 is offered while FULL and must never be taken
    drive(1'b1, 1'b0, 2'b11, 32'h333, 32'h0, 32'h0, 32'h0, 4'h3, 5'd12, 1'b1);
    check("bp_full_ready", {31'd0, in_ready}, 32'd0);
    check("bp_full_stall", stall_cnt, 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_rd", {27'd0, out_rd}, 32'd10);
      check("bp_hold_a", out_a, 32'h111);
    end
    check("bp_stall6", stall_cnt, 32'd6);
    idle();
    out_ready = 1'b1;
    #1;
    check("bp_no_comb_ready", {31'd0, in_ready}, 32'd0);
    step();
    check("bp_e2_valid", {31'd0, out_valid}, 32'd1);
    check("bp_e2_a", out_a, 32'h222);
    check("bp_e2_rd", {27'd0, out_rd}, 32'd11);
    check("bp_ready_back", {31'd0, in_ready}, 32'd1);
    step();
    check("bp_drain", {31'd0, out_valid}, 32'd0);
    check("bp_stall_final", stall_cnt, 32'd6);

    // Streaming: 100 back-to-back entries, 1-cycle latency, no stalls
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 1'b0, 2'b11, 32'(i) + 32'h1000, 32'h0, 32'h0, 32'h0, 4'(i), 5'(i), 1'b1);
      step();
      check("st_valid", {31'd0, out_valid}, 32'd1);
      check("st_a", out_a, 32'(i) + 32'h1000);
      check("st_rd", {27'd0, out_rd}, 32'(i % 32));
      check("st_ready", {31'd0, in_ready}, 32'd1);
    end
    idle();
    step();
    check("st_drain", {31'd0, out_valid}, 32'd0);
    check("st_stall", stall_cnt, 32'd6);

    // Flush from FULL with in_valid high; the offered entry is dropped
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 2'b11, 32'hA1, 32'h0, 32'h0, 32'h0, 4'h1, 5'd1, 1'b1);
    step();
    drive(1'b1, 1'b0, 2'b11, 32'hA2, 32'h0, 32'h0, 32'h0, 4'h2, 5'd2, 1'b1);
    step();
    check("fl_full", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    drive(1'b1, 1'b0, 2'b11, 32'hA3, 32'h0, 32'h0, 32'h0, 4'h3, 5'd3, 1'b1);
    step();
    flush = 1'b0;
    check_empty("fl_empty");
    check("fl_stall", stall_cnt, 32'd8);
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 2'b11, 32'hA4, 32'h0, 32'h0, 32'h0, 4'h4, 5'd4, 1'b1);
    step();
    check("fl_next_valid", {31'd0, out_valid}, 32'd1);
    check("fl_next_a", out_a, 32'hA4);
    // Flush in ONE with both in and out firing: input entry discarded
    flush = 1'b1;
    drive(1'b1, 1'b0, 2'b11, 32'hA5, 32'h0, 32'h0, 32'h0, 4'h5, 5'd5, 1'b1);
    step();
    flush = 1'b0;
    idle();
    check_empty("fl_one_empty");
    step();
    check("fl_one_lost", {31'd0, out_valid}, 32'd0);
    check("fl_one_stall", stall_cnt, 32'd8);

    // Stall counter wrap
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 2'b11, 32'hC0, 32'h0, 32'h0, 32'h0, 4'h0, 5'd9, 1'b0);
    step();
    idle();
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt_q;
    check("wr_preset", stall_cnt, 32'hFFFF_FFFE);
    step();
    check("wr_max", stall_cnt, 32'hFFFF_FFFF);
    step();
    check("wr_zero", stall_cnt, 32'h0);
    step();
    check("wr_one", stall_cnt, 32'h1);
    check("wr_held_a", out_a, 32'hC0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exu_issue_buf.md
# exu_issue_buf

Two-entry skid buffer between the instruction decoder and the ALU. It forms the ALU operands from decoded sources, registers them with the ALU control code and writeback tag, and presents them to the execute stage over a valid/ready handshake. Back-pressure never creates a combinational ready path from execute to decode. It also keeps a back-pressure cycle counter for performance measurement.

## Interface
- XLEN, 32, datapath width; must match the ALU A/B/out width.
- RW, 5, register-index width of the rd tag.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; drops all buffered entries.
- in_valid  in  1  decoder has an instruction.
- in_ready  out  1  buffer can accept; equals (state != FULL), taken from a register.
- in_rs1, in_rs2, in_imm, in_pc  in  XLEN  decoded sources.
- in_asel  in  1  operand A select: 0 → rs1, 1 → pc.
- in_bsel  in  2  operand B select: 00 → rs2, 01 → imm, 10 → constant 4, 11 → 0.
- in_ctr  in  4  ALU control code, passed through unchanged.
- in_rd  in  RW  destination register.
- in_wen  in  1  register write enable.
- out_valid  out  1  entry presented to the ALU.
- out_ready  in  1  ALU/writeback consumes this cycle.
- out_a, out_b  out  XLEN  ALU operands A and B.
- out_ctr  out  4  ALU ctr.
- out_rd  out  RW  destination tag.
- out_wen  out  1  write enable tag.
- out_pc  out  XLEN  pc of the presented entry.
- stall_cnt  out  32  count of cycles with out_valid && !out_ready.

## Operation
- Operands are muxed per asel/bsel at the input and stored in muxed form. Only a, b, ctr, rd, wen and pc are stored.
- Storage has two slots: MAIN, which drives out_*, and SKID.
- Input fire = in_valid && in_ready. Output fire = out_valid && out_ready.
- States: EMPTY (no valid slot), ONE (MAIN valid), FULL (MAIN and SKID valid). out_valid = (state != EMPTY).
- EMPTY:
  - in fire → MAIN ← input, go to ONE.
  - Otherwise hold.
- ONE:
  - in fire and out fire → MAIN ← input, stay in ONE.
  - out fire only → go to EMPTY.
  - in fire only → SKID ← input, go to FULL.
  - Neither → hold.
- FULL:
  - in_ready = 0.
  - out fire → MAIN ← SKID, go to ONE.
  - Otherwise hold.
- flush has the highest priority. State goes to EMPTY next cycle. Any input or output fire in the flush cycle has no buffering effect: the input entry is discarded. An output fire in that cycle still counts as consumed by the ALU.
- Payload of an invalid slot is don't-care for checking. The implementation clears it to 0 on reset only.
- out_* are stable while out_valid && !out_ready, and are held until fire or flush.
- Order is strictly FIFO. No entry is duplicated or lost unless flushed.
- stall_cnt increments by 1 every cycle out_valid && !out_ready, including a flush cycle. It wraps from 0xFFFFFFFF to 0. It is cleared only by rst.

## Timing
- Latency: input accepted in cycle N appears on out_* with out_valid in cycle N+1 when the buffer was EMPTY, or when it was ONE and out fired in N.
- Throughput: 1 entry/cycle sustained while out_ready = 1.
- in_ready depends only on registered state, with no combinational path from out_ready. out_valid is likewise registered.
- After out_ready drops, decode may still push exactly one more entry (into SKID). in_ready falls in the following cycle.
- Reset values while rst is high and after it falls: state EMPTY, out_valid 0, in_ready 1, out_a/out_b/out_pc 0, out_ctr 0, out_rd 0, out_wen 0, stall_cnt 0.
- in_valid during rst is ignored.
- rst asserted mid-operation clears both slots and the counter immediately, asynchronously.

## Test plan
- Reset/idle: assert rst mid-stream with FULL buffer → out_valid=0, in_ready=1, stall_cnt=0 immediately. First input after release, asel=0, bsel=01, rs1=0x10, imm=0x5, ctr=0000 → next cycle out_a=0x10, out_b=0x5, out_ctr=0.
- Operand select: pc=0x80000000, asel=1, bsel=10 → out_a=0x80000000, out_b=4. bsel=11 → out_b=0. bsel=00 with rs2=0xDEADBEEF → out_b=0xDEADBEEF.
- Back-pressure: out_ready=0, push entries E1, E2 → E2 held in SKID, in_ready=0 in the cycle after E2 was accepted. Hold 5 cycles → stall_cnt=6 (5 hold cycles plus the E2-accept cycle). Release → E1 then E2 on consecutive cycles, in_ready=1 again.
- Streaming: out_ready=1, 100 back-to-back inputs with incrementing rd → 100 outputs in order, one per cycle, 1-cycle latency, stall_cnt=0.
- Flush: FULL state, assert flush with in_valid=1 → next cycle out_valid=0, state EMPTY, flushed-cycle input never appears. Next input appears normally.
- Counter wrap: force back-pressure with stall_cnt preset near 0xFFFFFFFF via a long run or a bench force → rolls to 0, then 1.
